// File: rtl/add_mul_mix_seq.sv
// Sums two operand pairs, then multiplies the sums with a bit-serial shift-add multiplier.
// Latency: out_valid rises WIDTH+2 edges after acceptance; one operation in flight at a time.
// Backpressure: in_ready only in IDLE; DONE holds result stable until out_ready.
module add_mul_mix_seq #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   c,
   input  logic [WIDTH-1:0]   d,
   input  logic               ext_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               result_ovf
);

   // Accumulator holds the full product of two (WIDTH+1)-bit sums.
   localparam int AW = 2*WIDTH + 2;
   // Iteration counter must reach WIDTH.
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      MUL  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;

   // Operands captured at acceptance; later input changes cannot reach the datapath.
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] op_c;
   logic [WIDTH-1:0] op_d;
   logic             op_ext;

   // Sums with an optional carry bit.
   logic [WIDTH:0]   sum1;
   logic [WIDTH:0]   sum2;

   // Shift-add multiplier state.
   logic [AW-1:0]    mcand;
   logic [WIDTH:0]   mplier;
   logic [AW-1:0]    acc;
   logic [CW-1:0]    iter;

   logic             accept;
   logic             last_iter;

   assign accept    = in_valid && (state == IDLE);
   assign last_iter = (iter == LAST_ITER);

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = ADD;
            end
         end
         ADD: begin
            state_nxt = MUL;
         end
         MUL: begin
            if (last_iter) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Sums of the captured operands; the carry is dropped in wrap mode.
   always_comb begin
      sum1 = {1'b0, op_a} + {1'b0, op_b};
      sum2 = {1'b0, op_c} + {1'b0, op_d};
      if (!op_ext) begin
         sum1[WIDTH] = 1'b0;
         sum2[WIDTH] = 1'b0;
      end
   end

   // Operand capture on the accepting edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a   <= '0;
         op_b   <= '0;
         op_c   <= '0;
         op_d   <= '0;
         op_ext <= 1'b0;
      end else if (accept) begin
         op_a   <= a;
         op_b   <= b;
         op_c   <= c;
         op_d   <= d;
         op_ext <= ext_mode;
      end
   end

   // Multiplier: ADD loads the sums, MUL consumes one multiplier bit per cycle, LSB first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         iter   <= '0;
      end else begin
         case (state)
            ADD: begin
               mcand  <= AW'(sum1);
               mplier <= sum2;
               acc    <= '0;
               iter   <= '0;
            end
            MUL: begin
               if (mplier[0]) begin
                  acc <= acc + mcand;
               end
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               iter   <= last_iter ? '0 : iter + 1'b1;
            end
            default: begin
               // Accumulator keeps the finished product through DONE and IDLE.
            end
         endcase
      end
   end

   // Result is exposed only while valid so partial products never appear on the outputs.
   always_comb begin
      result     = '0;
      result_ovf = 1'b0;
      if (state == DONE) begin
         result     = acc[2*WIDTH-1:0];
         result_ovf = |acc[AW-1:2*WIDTH];
      end
   end

endmodule

// File: tb/tb_add_mul_mix_seq.sv
// Bench for add_mul_mix_seq at WIDTH=4: directed vectors with literal expectations
// plus a transaction-level model compared against the outputs every cycle.
module tb_add_mul_mix_seq;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic [W-1:0]   c = '0;
   logic [W-1:0]   d = '0;
   logic           ext_mode = 1'b0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [2*W-1:0] result;
   logic           result_ovf;

   int checks = 0;
   int errors = 0;

   add_mul_mix_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c(c), .d(d), .ext_mode(ext_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_ovf(result_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: {ovf, low 2W bits} of the product of the two sums.
   function automatic logic [8:0] ref_op(input int ra, input int rb, input int rc,
                                         input int rd, input logic m);
      int s1, s2, p;
      s1 = ra + rb;
      s2 = rc + rd;
      if (!m) begin
         s1 = s1 % (1 << W);
         s2 = s2 % (1 << W);
      end
      p = s1 * s2;
      return {(p >= (1 << (2*W))), 8'(p % (1 << (2*W)))};
   endfunction

   // Transaction model: busy from acceptance until the output handshake.
   bit         run = 0;
   bit         m_busy = 0;
   int         m_since = 0;
   logic [8:0] m_exp = '0;

   always @(negedge clk) begin
      if (run) begin
         bit ev;
         if (rst) m_busy = 0;
         ev = m_busy && (m_since >= W + 2);
         chk("model_in_ready", in_ready, !m_busy);
         chk("model_out_valid", out_valid, ev);
         if (ev) begin
            chk("model_result", result, m_exp[7:0]);
            chk("model_ovf", result_ovf, m_exp[8]);
         end
         if (!rst) begin
            if (!m_busy) begin
               if (in_valid) begin
                  m_busy  = 1;
                  m_since = 0;
                  m_exp   = ref_op(a, b, c, d, ext_mode);
               end
            end else if (ev && out_ready) begin
               m_busy = 0;
            end else begin
               m_since++;
            end
         end
      end
   end

   // Offer an operation, let it be accepted, scramble inputs, and wait for out_valid.
   task automatic launch(input logic [3:0] ta, input logic [3:0] tb_, input logic [3:0] tc,
                         input logic [3:0] td, input logic tm, output int lat);
      bit seen;
      @(posedge clk); #1;
      a = ta; b = tb_; c = tc; d = td; ext_mode = tm; in_valid = 1'b1;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (in_ready) seen = 1;
      end
      if (!seen) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
      ext_mode = 1'($urandom);
      lat = 0;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid) seen = 1;
      end
      if (!seen) chk("done_timeout", 0, 1);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("after_consume_out_valid", out_valid, 0);
      chk("after_consume_in_ready", in_ready, 1);
   endtask

   task automatic directed(input string name, input logic [3:0] ta, input logic [3:0] tb_,
                           input logic [3:0] tc, input logic [3:0] td, input logic tm,
                           input logic [7:0] er, input logic eo);
      int lat;
      launch(ta, tb_, tc, td, tm, lat);
      chk({name, "_latency"}, lat, W + 2);
      chk({name, "_result"}, result, er);
      chk({name, "_ovf"}, result_ovf, eo);
      consume();
   endtask

   initial begin
      int lat;
      logic [7:0] held;

      // Pin the reference arithmetic with hand-computed products.
      chk("ref_basic", ref_op(3, 2, 1, 4, 0), 9'h019);
      chk("ref_wrap",  ref_op(15, 1, 7, 2, 0), 9'h000);
      chk("ref_ext",   ref_op(15, 1, 15, 15, 1), 9'h1E0);
      chk("ref_max",   ref_op(15, 0, 15, 0, 1), 9'h0E1);

      // Reset state, visible without any clock edge.
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_result", result, 0);
      chk("reset_ovf", result_ovf, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      run = 1;

      directed("basic", 3, 2, 1, 4, 0, 8'h19, 0);
      directed("wrap", 15, 1, 7, 2, 0, 8'h00, 0);
      directed("ext_ovf", 15, 1, 15, 15, 1, 8'hE0, 1);
      directed("max_no_ovf", 15, 0, 15, 0, 1, 8'hE1, 0);
      directed("ext_small", 5, 6, 2, 1, 1, 8'h21, 0);

      // Backpressure: hold DONE while new requests and operand changes are offered.
      launch(9, 4, 3, 3, 0, lat);
      chk("bp_latency", lat, W + 2);
      held = result;
      chk("bp_result", held, 8'h4E);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
         @(posedge clk); #1;
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_result", result, held);
      end
      // Handshake with in_valid still high: the next op goes in one edge later.
      a = 1; b = 2; c = 3; d = 4; ext_mode = 0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_idle_after_hs", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_accepted", in_ready, 0);
      lat = 0;
      for (int i = 0; i < 40 && !out_valid; i++) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp_next_latency", lat, W + 2);
      chk("bp_next_result", result, 8'h15);
      consume();
      @(posedge clk); #1;
      chk("bp_no_extra_op", in_ready, 1);

      // Reset in the third MUL cycle aborts the operation immediately.
      @(posedge clk); #1;
      a = 7; b = 7; c = 7; d = 7; ext_mode = 1; in_valid = 1'b1;
      @(posedge clk); #1;          // accepted
      in_valid = 1'b0;
      repeat (3) @(posedge clk);   // ADD, MUL iter 0, MUL iter 1
      #1;
      rst = 1'b1;
      #1;
      chk("midreset_out_valid", out_valid, 0);
      chk("midreset_in_ready", in_ready, 1);
      chk("midreset_result", result, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      directed("after_reset", 2, 2, 3, 0, 0, 8'h0C, 0);

      // Mixed-mode sweep checked by the model.
      for (int i = 0; i < 12; i++) begin
         launch(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), lat);
         chk("sweep_latency", lat, W + 2);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         consume();
      end

      repeat (3) @(posedge clk);
      run = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/add_mul_mix_seq.md
ADD_MUL_MIX_SEQ -- requirements
Module: add_mul_mix_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand set a/b/c/d/ext_mode is valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand set.
REQ-006 SHALL have ports a, b, c, d  input  WIDTH  unsigned operands.
REQ-007 SHALL have port ext_mode  input  1  0 = wrap sums to WIDTH bits; 1 = keep sum carries.
REQ-008 SHALL have port out_valid  output  1  result and result_ovf are valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port result  output  2*WIDTH  product of the two sums, low 2*WIDTH bits.
REQ-011 SHALL have port result_ovf  output  1  full product does not fit in 2*WIDTH bits.

Function
REQ-012 SHALL implement states IDLE, ADD, MUL, DONE; the state SHALL be encoded in no more than 2 bits.
REQ-013 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-014 Acceptance: when in_valid && in_ready at an edge, SHALL register a, b, c, d and ext_mode, then go IDLE->ADD.
REQ-015 ADD (1 cycle): SHALL form s1 = a+b and s2 = c+d as (WIDTH+1)-bit values; when the captured ext_mode = 0, bit WIDTH of each sum SHALL be cleared.
REQ-016 MUL: SHALL run an iterative shift-add over exactly WIDTH+1 cycles, one multiplier bit of s2 per cycle, LSB first, into a (2*WIDTH+2)-bit accumulator; an iteration counter SHALL count 0..WIDTH.
REQ-017 After the final iteration, SHALL go MUL->DONE.
REQ-018 In DONE, result SHALL equal accumulator[2*WIDTH-1:0] and result_ovf SHALL equal OR(accumulator[2*WIDTH+1:2*WIDTH]).
REQ-019 With ext_mode = 0, result_ovf SHALL always be 0.
REQ-020 Latency: an acceptance at edge T SHALL raise out_valid after edge T+WIDTH+2 (T+6 for WIDTH=4).
REQ-021 Throughput: SHALL accept one operation per WIDTH+3 cycles at most; in_valid seen while busy SHALL be ignored, with no queuing.
REQ-022 Backpressure: DONE SHALL hold with result and result_ovf stable while out_ready = 0; out_valid && out_ready SHALL move DONE->IDLE on that edge.
REQ-023 Captured operands SHALL be immune to input changes after acceptance.
REQ-024 A new acceptance SHALL NOT occur on the same edge as a DONE->IDLE transition, because in_ready = 0 in DONE.
REQ-025 Arithmetic SHALL be unsigned throughout, and no X SHALL propagate to outputs after reset.

Reset
REQ-026 rst = 1 SHALL immediately, without waiting for a clock edge, force: state IDLE, in_ready = 1, out_valid = 0, result = 0, result_ovf = 0, accumulator and counter = 0.
REQ-027 rst asserted in any state, including mid-MUL, SHALL abort the operation; after release, the first accepted operation SHALL complete with correct latency.
REQ-028 Release of rst SHALL be synchronised externally; the block requires no reset-release cycles.

Verification (WIDTH=4)
REQ-029 Basic: a=3, b=2, c=1, d=4, ext_mode=0 -> result=0x19 (25), ovf=0, out_valid 6 cycles after acceptance.
REQ-030 Wrap: a=15, b=1, c=7, d=2, ext_mode=0 -> s1 wraps to 0 -> result=0x00, ovf=0.
REQ-031 Extended overflow: a=15, b=1, c=15, d=15, ext_mode=1 -> 16*30=480 -> result=0xE0, ovf=1.
REQ-032 Max without overflow: a=15, b=0, c=15, d=0, ext_mode=1 -> result=0xE1, ovf=0.
REQ-033 Backpressure/ignore: out_ready=0 for 5 cycles in DONE with in_valid=1 and operands toggling -> result stable; exactly one further op accepted only after the out_ready handshake.
REQ-034 Reset mid-op: assert rst in the 3rd MUL cycle -> out_valid=0 and in_ready=1 with no clock edge; next op a=2, b=2, c=3, d=0 -> result=0x0C.
